// File: rtl/sw_pkg.sv
// Shared constants for the board switch/button conditioning path.
package sw_pkg;
  localparam int SW_WIDTH               = 16;
  localparam int DEBOUNCE_CYCLES_100MHZ = 1000000;
  // Short window so simulations settle in a handful of cycles.
  localparam int DEBOUNCE_CYCLES_SIM    = 4;
endpackage

// File: rtl/switch_debounce_if.sv
// Debounced switch bundle between the raw pins, the debouncer and the display stage.
interface switch_debounce_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] switches;
  logic [WIDTH-1:0] sw_db;
  logic             sw_valid;
  logic             sw_changed;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (output switches,
                  input  sw_db, sw_valid, sw_changed, sw_rise, sw_fall);
  modport slave  (input  switches,
                  output sw_db, sw_valid, sw_changed, sw_rise, sw_fall);
endinterface

// File: rtl/sync_2ff.sv
// Plain two-flop synchroniser, no logic between the stages; reused for buttons.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;
endmodule

// File: rtl/switch_debounce.sv
// Vector debouncer: a value is accepted once the synchronised pins hold still for
// STABLE_CYCLES cycles; acceptance of a new value emits change/rise/fall pulses.
module switch_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
  input  logic             clk,
  input  logic             rst,
  switch_debounce_if.slave bus
);
  localparam int            CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic             valid_q, valid_d;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.switches),
    .q_o (sync2)
  );

  // Any bit moving restarts the window for the whole vector; the counter
  // saturates so a held value is re-evaluated every cycle without re-pulsing.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    valid_d = valid_q;
    chg_d   = 1'b0;
    rise_d  = '0;
    fall_d  = '0;
    if (sync2 != cand_q) begin
      cand_d = sync2;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      valid_d = 1'b1;
      if (cand_q != db_q) begin
        db_d   = cand_q;
        chg_d  = 1'b1;
        rise_d = cand_q & ~db_q;
        fall_d = ~cand_q & db_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q  <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.sw_db      = db_q;
  assign bus.sw_valid   = valid_q;
  assign bus.sw_changed = chg_q;
  assign bus.sw_rise    = rise_q;
  assign bus.sw_fall    = fall_q;
endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream conditioning stage for the seven-segment display driver.
- Synchronises the raw 16 board slide switches into clk, debounces them as a vector, and presents a stable value to the display stage.
- Also emits a one-cycle change strobe and per-bit rise/fall pulses, so the display stage and later control logic can react to edits without re-sampling raw pins.

Parameters:
- WIDTH, 16, number of switch bits.
- STABLE_CYCLES, 1000000, consecutive clk cycles the synchronised vector must hold before it is accepted (10 ms at 100 MHz). Legal range is at least 2. Benches override it to 4.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst  input  1  synchronous, active-high reset.
- switches  input  WIDTH  raw asynchronous switch pins.
- sw_db  output  WIDTH  debounced switch value; feeds the display stage's switches input.
- sw_valid  output  1  sticky; high once the first stable value has been accepted since reset.
- sw_changed  output  1  one-cycle pulse when sw_db updates to a different value.
- sw_rise  output  WIDTH  one-cycle per-bit pulses for bits that went 0 to 1 on that update.
- sw_fall  output  WIDTH  one-cycle per-bit pulses for bits that went 1 to 0 on that update.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Every register changes only on the rising edge of clk.
- Reset values: sync1, sync2, cand, sw_db = 0; cnt = 0; sw_valid = 0; sw_changed = 0; sw_rise = 0; sw_fall = 0. rst takes priority over all other logic on the same edge.
- Synchroniser: two flops per bit, switches to sync1 to sync2. No logic between the two flops.
- Candidate register cand and counter cnt, width $clog2(STABLE_CYCLES). Per edge, evaluated in order:
  - If sync2 != cand: cand <= sync2, cnt <= 0. Any single-bit difference restarts the window for the whole vector.
  - Else if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Else, the terminal state: cnt holds at STABLE_CYCLES-1 (saturates, never wraps). sw_valid <= 1. If cand != sw_db, then on the same edge:
    - sw_db <= cand
    - sw_changed <= 1
    - sw_rise <= cand & ~sw_db
    - sw_fall <= ~cand & sw_db
- Pulse outputs: default to 0 on every edge not described above. The terminal state with cand == sw_db produces no pulse, so sw_changed never fires twice for one value.
- Latency: take edge 0 as the edge where sync1 first captures a new pin value that then stays put. The resulting sequence is:
  - sync2 updates at edge 1.
  - cand updates at edge 2.
  - cnt reaches STABLE_CYCLES-1 at edge STABLE_CYCLES+1.
  - sw_db and the pulses update at edge STABLE_CYCLES+2.
- Bounce: any toggle seen at sync2 before the terminal state discards the window. sw_db holds its old value throughout.
- Post-reset start-up: sw_valid rises after cand has been stable for STABLE_CYCLES cycles. If the accepted value is 0, no sw_changed pulse occurs. If it is non-zero, sw_changed and sw_rise pulse on the same edge that sw_valid rises.
- Reset mid-window: all state clears. No pulse is emitted on or after the reset edge until a new full window completes.
- Simultaneous multi-bit change: accepted as a single update, with one sw_changed pulse and multiple rise/fall bits set.

Decomposition:
- Shared package sw_pkg holds:
  - SW_WIDTH = 16
  - DEBOUNCE_CYCLES_100MHZ = 1000000
  - a sim-only override constant DEBOUNCE_CYCLES_SIM = 4
- Natural sub-module: sync_2ff, a parameterised-width two-flop synchroniser with synchronous active-high reset. It is reused later for button inputs.
- The debounce counter and edge logic stay in switch_debounce.

Test Plan (STABLE_CYCLES=4):
- Reset, switches=0 held: sw_valid rises, sw_changed never pulses, sw_db=0x0000.
- After valid, switches 0x0000 to 0x00A5 at edge 0: sw_db=0x00A5 at edge 6, sw_changed=1 for exactly one cycle, sw_rise=0x00A5, sw_fall=0.
- Bounce: bit0 toggles 0,1,0,1 on consecutive edges, then holds 1: sw_db stays 0 until 6 edges after the final toggle is captured, then exactly one pulse with sw_rise=0x0001.
- From 0x00A5, switches go to 0xFF00: single update with sw_rise=0xFF00 and sw_fall=0x00A5.
- rst asserted at edge 4 of a pending 0x1234 window: all outputs 0 on the next cycle. After release with 0x1234 held, sw_valid, sw_changed and sw_rise=0x1234 all assert on the same edge.
- Input held at 0xFFFF for 100 cycles after acceptance: cnt saturates, no further sw_changed pulses.
